// File: rtl/apb_timer.sv
// rtl/apb_timer.sv - APB completer with a prescaled 32-bit timer and compare interrupt
//
// Purpose:
//   Memory-mapped timer on the peripheral APB bus. Five 32-bit registers at
//   BASE_ADDR: CTRL {reload, ie, en}, STATUS {pending} (W1C), COUNT, COMPARE,
//   PRESCALE {ps[15:0]}. Offsets 0x14-0x1C and anything outside the 32-byte
//   window answer with perr. The interrupt output is a registered level of
//   pending & ie.
//
// Optional feature macro: APB_WAIT_EN
//   defined   -> one wait state per access (pready low in first access cycle)
//   undefined -> zero-wait responder
//
// Ports:
//   APB_PCLK     in   clock, rising edge
//   APB_PRESET   in   synchronous active-high reset
//   APB_paddr    in   byte address ([1:0] ignored)
//   APB_pdata    in   write data
//   APB_prdata   out  read data, registered at the setup edge
//   APB_psel     in   select
//   APB_penable  in   access phase
//   APB_pwrite   in   1 = write, 0 = read
//   APB_pstb     in   write byte strobes
//   APB_pready   out  transfer complete
//   APB_perr     out  slave error, qualified by pready
//   interrupt    out  level interrupt = pending & CTRL.ie (registered)

module apb_timer #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h2000
) (
  input  logic                  APB_PCLK,
  input  logic                  APB_PRESET,
  input  logic [ADDR_WIDTH-1:0] APB_paddr,
  input  logic [DATA_WIDTH-1:0] APB_pdata,
  output logic [DATA_WIDTH-1:0] APB_prdata,
  input  logic                  APB_psel,
  input  logic                  APB_penable,
  input  logic                  APB_pwrite,
  input  logic [3:0]            APB_pstb,
  output logic                  APB_pready,
  output logic                  APB_perr,
  output logic                  interrupt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [2:0]            ctrl_q, ctrl_d;        // {reload, ie, en}
  logic                  pending_q, pending_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic [15:0]           ps_q, ps_d;
  logic [15:0]           pcnt_q, pcnt_d;
  logic                  irq_q, irq_d;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_window;
  logic [2:0]            reg_idx;
  logic                  mapped;
  logic                  unused_addr_bits;

  assign offset           = APB_paddr - BASE_ADDR;
  // The subtraction alone would wrap addresses below the base into range.
  assign in_window        = (APB_paddr >= BASE_ADDR) && (offset[ADDR_WIDTH-1:5] == '0);
  assign reg_idx          = offset[4:2];
  assign mapped           = in_window && (reg_idx <= 3'd4);
  assign unused_addr_bits = ^offset[1:0];

  logic setup_phase, access_phase;
  assign setup_phase  = APB_psel & ~APB_penable;
  assign access_phase = APB_psel & APB_penable;

  // ---------------------------------------------------------------------------
  // Responder FSM
  // S_SETUP means the previous cycle was a setup cycle, so a psel&penable now
  // is the first access cycle. S_ACCESS marks a completed transfer; from there a
  // fresh setup is accepted immediately (back-to-back).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    APB_pready = 1'b0;
    unique case (state_q)
      S_IDLE, S_ACCESS: begin
        state_d = setup_phase ? S_SETUP : S_IDLE;
      end
      S_SETUP: begin
        if (access_phase) begin
`ifdef APB_WAIT_EN
          state_d = S_WAIT;
`else
          APB_pready = 1'b1;
          state_d    = S_ACCESS;
`endif
        end else begin
          state_d = setup_phase ? S_SETUP : S_IDLE;
        end
      end
      S_WAIT: begin
        if (access_phase) begin
          APB_pready = 1'b1;
          state_d    = S_ACCESS;
        end else begin
          state_d = setup_phase ? S_SETUP : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign APB_perr = APB_pready & ~mapped;

  // ---------------------------------------------------------------------------
  // Read mux, captured at the setup edge
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (mapped) begin
      unique case (reg_idx)
        3'd0:    rdata = {29'b0, ctrl_q};
        3'd1:    rdata = {31'b0, pending_q};
        3'd2:    rdata = count_q;
        3'd3:    rdata = compare_q;
        3'd4:    rdata = {16'b0, ps_q};
        default: rdata = '0;
      endcase
    end
  end

  assign prdata_d   = setup_phase ? rdata : prdata_q;
  assign APB_prdata = prdata_q;

  // ---------------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  stb);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (stb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  logic wr_en, wr_ctrl, wr_status, wr_count, wr_compare, wr_ps;

  assign wr_en      = APB_pready & APB_pwrite & mapped;
  assign wr_ctrl    = wr_en && (reg_idx == 3'd0);
  assign wr_status  = wr_en && (reg_idx == 3'd1);
  assign wr_count   = wr_en && (reg_idx == 3'd2);
  assign wr_compare = wr_en && (reg_idx == 3'd3);
  assign wr_ps      = wr_en && (reg_idx == 3'd4);

  // ---------------------------------------------------------------------------
  // Timer datapath
  // ---------------------------------------------------------------------------
  logic tick, hit;

  assign tick = ctrl_q[0] && (pcnt_q == ps_q);
  assign hit  = tick && (count_q == compare_q);

  always_comb begin
    ctrl_d    = ctrl_q;
    compare_d = compare_q;
    ps_d      = ps_q;
    pcnt_d    = pcnt_q;
    count_d   = count_q;
    pending_d = pending_q;

    if (wr_ctrl && APB_pstb[0]) ctrl_d = APB_pdata[2:0];
    if (wr_compare)             compare_d = merge_bytes(compare_q, APB_pdata, APB_pstb);
    if (wr_ps) begin
      if (APB_pstb[0]) ps_d[7:0]  = APB_pdata[7:0];
      if (APB_pstb[1]) ps_d[15:8] = APB_pdata[15:8];
    end

    if (wr_ps) begin
      pcnt_d = 16'd0;
    end else if (ctrl_q[0]) begin
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
    end

    // A bus write to COUNT overrides the increment of the same cycle.
    if (wr_count) begin
      count_d = merge_bytes(count_q, APB_pdata, APB_pstb);
    end else if (tick) begin
      count_d = (hit && ctrl_q[2]) ? 32'd0 : count_q + 32'd1;
    end

    // Hardware set is applied after the W1C so it wins a same-cycle race.
    if (wr_status && APB_pstb[0] && APB_pdata[0]) pending_d = 1'b0;
    if (hit)                                      pending_d = 1'b1;
  end

  assign irq_d     = pending_q & ctrl_q[1];
  assign interrupt = irq_q;

  always_ff @(posedge APB_PCLK) begin
    if (APB_PRESET) begin
      state_q   <= S_IDLE;
      prdata_q  <= '0;
      ctrl_q    <= 3'b0;
      pending_q <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ps_q      <= 16'd0;
      pcnt_q    <= 16'd0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ps_q      <= ps_d;
      pcnt_q    <= pcnt_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// tb/tb_apb_timer.sv - bench for apb_timer

module tb_apb_timer;

  localparam logic [31:0] BASE       = 32'h2000;
  localparam logic [31:0] A_CTRL     = BASE + 32'h00;
  localparam logic [31:0] A_STATUS   = BASE + 32'h04;
  localparam logic [31:0] A_COUNT    = BASE + 32'h08;
  localparam logic [31:0] A_COMPARE  = BASE + 32'h0C;
  localparam logic [31:0] A_PRESCALE = BASE + 32'h10;
`ifdef APB_WAIT_EN
  localparam int EXP_WAITS = 1;
`else
  localparam int EXP_WAITS = 0;
`endif
  // Edges from task start to the commit edge of a transfer.
  localparam int LAT = 2 + EXP_WAITS;

  logic        clk = 1'b0;
  logic        preset = 1'b1;
  logic [31:0] paddr = '0;
  logic [31:0] pdata = '0;
  logic [31:0] prdata;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [3:0]  pstb = 4'h0;
  logic        pready;
  logic        perr;
  logic        irq;

  apb_timer #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDR (BASE)
  ) dut (
    .APB_PCLK   (clk),
    .APB_PRESET (preset),
    .APB_paddr  (paddr),
    .APB_pdata  (pdata),
    .APB_prdata (prdata),
    .APB_psel   (psel),
    .APB_penable(penable),
    .APB_pwrite (pwrite),
    .APB_pstb   (pstb),
    .APB_pready (pready),
    .APB_perr   (perr),
    .interrupt  (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a transfer at the current time (just after an edge); returns just
  // after the completion edge with psel dropped, so a following call is
  // back-to-back.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] stb, output logic [31:0] rd, output logic err,
                     output int waits);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pdata = wd; pstb = stb;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    waits = 0;
    while (!pready && waits < 4) begin
      @(posedge clk); #1;
      waits++;
    end
    rd  = prdata;
    err = perr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic do_wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] stb,
                       input string tag);
    logic [31:0] rd;
    logic        err;
    int          waits;
    apb(1'b1, addr, wd, stb, rd, err, waits);
    check({tag, "_waits"}, waits, EXP_WAITS);
    check({tag, "_perr"}, err, 1'b0);
  endtask

  task automatic do_rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    logic        err;
    int          waits;
    apb(1'b0, addr, 32'h0, 4'h0, rd, err, waits);
    check(tag, rd, exp);
    check({tag, "_waits"}, waits, EXP_WAITS);
    check({tag, "_perr"}, err, 1'b0);
  endtask

  task automatic do_err(input logic wr, input logic [31:0] addr, input string tag);
    logic [31:0] rd;
    logic        err;
    int          waits;
    apb(wr, addr, 32'hFFFF_FFFF, 4'hF, rd, err, waits);
    check({tag, "_perr"}, err, 1'b1);
    check({tag, "_rdata"}, rd, 32'h0);
    check({tag, "_waits"}, waits, EXP_WAITS);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Counts edges until interrupt goes high, giving up after 60.
  task automatic wait_irq(output int n);
    n = 0;
    while (!irq && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int e0, ec, n;

  initial begin
    // Reset
    preset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pready", pready, 1'b0);
    check("rst_perr", perr, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_prdata", prdata, 32'h0);
    preset = 1'b0;
    idle(1);
    do_rd(A_CTRL, 32'h0, "rst_ctrl");
    do_rd(A_COUNT, 32'h0, "rst_count");
    do_rd(A_STATUS, 32'h0, "rst_status");

    // Byte strobes and reserved bits
    do_wr(A_COMPARE, 32'hAABBCCDD, 4'b0101, "wr_cmp_stb");
    do_rd(A_COMPARE, 32'h00BB00DD, "cmp_stb");
    do_wr(A_CTRL, 32'hFFFF_FFF8, 4'hF, "wr_ctrl_rsvd");
    do_rd(A_CTRL, 32'h0, "ctrl_rsvd");
    do_wr(A_PRESCALE, 32'hFFFF_1234, 4'hF, "wr_ps_rsvd");
    do_rd(A_PRESCALE, 32'h0000_1234, "ps_rsvd");

    // Errors: unmapped, above and below the window
    do_rd(A_COMPARE, 32'h00BB00DD, "cmp_before_err");
    do_err(1'b0, BASE + 32'h18, "err_rd_18");
    do_err(1'b1, BASE + 32'h1C, "err_wr_1c");
    do_err(1'b0, BASE + 32'h20, "err_rd_above");
    do_err(1'b0, BASE - 32'h4, "err_rd_below");
    do_rd(A_COMPARE, 32'h00BB00DD, "cmp_after_err");

    // Prescaled timer with compare interrupt
    do_wr(A_PRESCALE, 32'd2, 4'hF, "wr_ps2");
    do_wr(A_COMPARE, 32'd5, 4'hF, "wr_cmp5");
    do_wr(A_CTRL, 32'h3, 4'hF, "wr_ctrl3");
    e0 = cyc;
    wait_irq(n);
    check("irq_latency", n, 19);
    do_rd(A_COUNT, 32'd6, "count_after_hit");
    do_rd(A_STATUS, 32'd1, "pending_set");
    do_wr(A_CTRL, 32'h0, 4'hF, "wr_ctrl_off");
    ec = cyc;
    idle(5);
    do_rd(A_COUNT, (ec - e0) / 3, "count_frozen");
    idle(3);
    do_rd(A_COUNT, (ec - e0) / 3, "count_frozen2");
    check("irq_ie_off", irq, 1'b0);
    do_rd(A_STATUS, 32'd1, "pending_held");
    do_wr(A_STATUS, 32'h1, 4'b1110, "wr_w1c_nostb");
    do_rd(A_STATUS, 32'd1, "w1c_nostb");
    do_wr(A_STATUS, 32'h1, 4'hF, "wr_w1c");
    do_rd(A_STATUS, 32'd0, "w1c_clear");

    // Auto-reload, prescale 0
    do_wr(A_PRESCALE, 32'd0, 4'hF, "wr_ps0");
    do_wr(A_COMPARE, 32'd3, 4'hF, "wr_cmp3");
    do_wr(A_COUNT, 32'd0, 4'hF, "wr_cnt0");
    do_wr(A_CTRL, 32'h7, 4'hF, "wr_ctrl7");
    e0 = cyc;
    wait_irq(n);
    check("reload_irq_latency", n, 5);
    for (int i = 0; i < 4; i++) begin
      do_rd(A_COUNT, (cyc - e0) % 4, "reload_count");
    end

    // W1C landing on a match edge: set wins
    while (((cyc + LAT - e0) % 4) != 0) idle(1);
    do_wr(A_STATUS, 32'h1, 4'hF, "wr_w1c_race");
    do_rd(A_STATUS, 32'd1, "w1c_race");

    // Clear one edge after a match: reasserts at the next match
    while (((cyc + LAT - e0) % 4) != 1) idle(1);
    do_wr(A_STATUS, 32'h1, 4'hF, "wr_w1c_clr");
    idle(1);
    check("irq_dropped", irq, 1'b0);
    wait_irq(n);
    check("irq_reassert", n, 3);

    // COUNT write on a tick cycle wins over the increment
    do_wr(A_COUNT, 32'd100, 4'hF, "wr_cnt100");
    ec = cyc;
    do_rd(A_COUNT, 32'd100, "count_write_race");
    do_rd(A_COUNT, 32'd100 + (cyc - ec), "count_after_race");

    // ie cleared with pending set: interrupt drops, pending kept
    do_wr(A_CTRL, 32'h4, 4'hF, "wr_ctrl_ie0");
    idle(1);
    check("irq_ie_clear", irq, 1'b0);
    do_rd(A_STATUS, 32'd1, "pending_ie0");
    do_wr(A_CTRL, 32'h7, 4'hF, "wr_ctrl_ie1");
    idle(1);
    check("irq_ie_set", irq, 1'b1);

    // Reset in the middle of a transfer
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_COUNT; pstb = 4'h0;
    @(posedge clk); #1;
    penable = 1'b1;
    preset  = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0;
    #1;
    check("rst_mid_pready", pready, 1'b0);
    check("rst_mid_irq", irq, 1'b0);
    check("rst_mid_prdata", prdata, 32'h0);
    @(posedge clk); #1;
    check("rst_mid_pready2", pready, 1'b0);
    psel = 1'b0; penable = 1'b0;
    idle(1);
    do_rd(A_COUNT, 32'h0, "rst_mid_count");
    do_rd(A_CTRL, 32'h0, "rst_mid_ctrl");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
